outport_rr: RTL and testbench



---
 rtl/outport_rr.sv | 126 ++++++++++++
 tb/tb_outport_rr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outport_rr.sv
// rtl/outport_rr.sv - round-robin output port with downstream credit tracking and toggling diff-pair flit signalling
// Optional feature macro: OUTPORT_FLIT_COUNT_EN (adds flit_count_dout launch counter)
module outport_rr #(
    parameter int NUM_REQ      = 4,
    parameter int CHANNEL_W    = 48,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                           clka,
    input  logic                           rsta_n,
    input  logic [NUM_REQ-1:0]             request_din,
    input  logic [NUM_REQ*CHANNEL_W-1:0]   channel_din,
    input  logic                           credit_din,
    output logic [NUM_REQ-1:0]             grant_dout,
    output logic [1:0]                     diff_pair_dout,
    output logic [CHANNEL_W-1:0]           channel_dout,
    output logic [3:0]                     credit_count_dout
`ifdef OUTPORT_FLIT_COUNT_EN
    ,
    output logic [15:0]                    flit_count_dout
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [1:0]             diff_q, diff_d;
    logic [CHANNEL_W-1:0]   chan_q, chan_d;
    logic [3:0]             credit_q, credit_d;
`ifdef OUTPORT_FLIT_COUNT_EN
    logic [15:0]            flit_cnt_q, flit_cnt_d;
`endif

    logic [CHANNEL_W-1:0]   slice [NUM_REQ];
    logic                   found;
    logic                   launch;
    logic [PTR_W-1:0]       winner;
    logic [PTR_W-1:0]       cand;
    logic [4:0]             credit_sum;
    int                     idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = channel_din[g*CHANNEL_W +: CHANNEL_W];
    end

    // Search starts just after the last winner so every inport is served in turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PTR_W'(idx);
            if (!found && request_din[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign launch = (state_q == IDLE) && found && (credit_q != 4'd0);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = '0;
        diff_d     = diff_q;
        chan_d     = chan_q;
        credit_sum = {1'b0, credit_q} + {4'b0, credit_din} - {4'b0, launch};
        credit_d   = (credit_sum > 5'(BUFFER_DEPTH)) ? 4'(BUFFER_DEPTH) : credit_sum[3:0];
`ifdef OUTPORT_FLIT_COUNT_EN
        flit_cnt_d = launch ? flit_cnt_q + 16'd1 : flit_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (launch) begin
                    grant_d[winner] = 1'b1;
                    chan_d          = slice[winner];
                    diff_d          = ~diff_q;
                    rr_ptr_d        = winner;
                    state_d         = SEND;
                end
            end
            SEND:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
            grant_q    <= '0;
            diff_q     <= 2'b10;
            chan_q     <= '0;
            credit_q   <= 4'(BUFFER_DEPTH);
`ifdef OUTPORT_FLIT_COUNT_EN
            flit_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            diff_q     <= diff_d;
            chan_q     <= chan_d;
            credit_q   <= credit_d;
`ifdef OUTPORT_FLIT_COUNT_EN
            flit_cnt_q <= flit_cnt_d;
`endif
        end
    end

    assign grant_dout        = grant_q;
    assign diff_pair_dout    = diff_q;
    assign channel_dout      = chan_q;
    assign credit_count_dout = credit_q;
`ifdef OUTPORT_FLIT_COUNT_EN
    assign flit_count_dout   = flit_cnt_q;
`endif

endmodule

// File: tb/tb_outport_rr.sv
// tb/tb_outport_rr.sv - self-checking bench for outport_rr against a behavioural arbitration/credit model
module tb_outport_rr;

    localparam int NR = 4;
    localparam int CW = 48;
    localparam int BD = 4;

    logic               clka = 1'b0;
    logic               rsta_n = 1'b0;
    logic [NR-1:0]      request_din = '0;
    logic [NR*CW-1:0]   channel_din = '0;
    logic               credit_din = 1'b0;
    logic [NR-1:0]      grant_dout;
    logic [1:0]         diff_pair_dout;
    logic [CW-1:0]      channel_dout;
    logic [3:0]         credit_count_dout;
`ifdef OUTPORT_FLIT_COUNT_EN
    logic [15:0]        flit_count_dout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [NR-1:0]      m_gnt;
    logic [1:0]         m_dp;
    logic [CW-1:0]      m_ch;
    logic [3:0]         m_credit;
    logic [15:0]        m_flits;
    int                 m_last;
    bit                 m_busy;

    outport_rr #(.NUM_REQ(NR), .CHANNEL_W(CW), .BUFFER_DEPTH(BD)) dut (
        .clka              (clka),
        .rsta_n            (rsta_n),
        .request_din       (request_din),
        .channel_din       (channel_din),
        .credit_din        (credit_din),
        .grant_dout        (grant_dout),
        .diff_pair_dout    (diff_pair_dout),
        .channel_dout      (channel_dout),
        .credit_count_dout (credit_count_dout)
`ifdef OUTPORT_FLIT_COUNT_EN
        ,
        .flit_count_dout   (flit_count_dout)
`endif
    );

    always #5 clka = ~clka;

    function automatic void model_reset();
        m_gnt    = '0;
        m_dp     = 2'b10;
        m_ch     = '0;
        m_credit = 4'(BD);
        m_flits  = '0;
        m_last   = NR - 1;
        m_busy   = 1'b0;
    endfunction

    // One clock edge of the port as seen from outside: at most one flit per two cycles,
    // rotating priority, and a credit pool capped at the downstream buffer depth.
    function automatic void model_edge();
        bit hit;
        int w;
        int c;
        hit   = 1'b0;
        w     = 0;
        m_gnt = '0;
        if (!m_busy && request_din != '0 && m_credit != 4'd0) begin
            for (int k = 1; k <= NR; k++) begin
                if (!hit && request_din[2'((m_last + k) % NR)]) begin
                    hit = 1'b1;
                    w   = (m_last + k) % NR;
                end
            end
        end
        if (hit) begin
            m_gnt[2'(w)] = 1'b1;
            m_ch         = channel_din[w*CW +: CW];
            m_dp         = ~m_dp;
            m_last       = w;
            m_flits      = m_flits + 16'd1;
        end
        c = int'(m_credit) + int'(credit_din) - int'(hit);
        if (c > BD) c = BD;
        m_credit = 4'(c);
        m_busy   = hit;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clka);
        #1;
    endtask

    task automatic do_reset();
        rsta_n      = 1'b0;
        request_din = '0;
        credit_din  = 1'b0;
        @(posedge clka);
        #1;
        rsta_n = 1'b1;
        model_reset();
    endtask

    task automatic randomize_channels();
        channel_din = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic test_reset();
        rsta_n      = 1'b0;
        request_din = 4'b1111;
        repeat (10) @(posedge clka);
        #1;
        n_cmp++;
        if (grant_dout !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got=%b want=0000", grant_dout); end
        n_cmp++;
        if (diff_pair_dout !== 2'b10) begin n_bad++; $display("FAIL reset_dp got=%b want=10", diff_pair_dout); end
        n_cmp++;
        if (channel_dout !== 48'h0) begin n_bad++; $display("FAIL reset_ch got=%h want=0", channel_dout); end
        n_cmp++;
        if (credit_count_dout !== 4'd4) begin n_bad++; $display("FAIL reset_credit got=%0d want=4", credit_count_dout); end
        request_din = '0;
        rsta_n      = 1'b1;
        model_reset();
    endtask

    task automatic test_single_flit();
        channel_din = '0;
        channel_din[2*CW +: CW] = 48'h02a987654321;
        request_din = 4'b0100;
        tick();
        n_cmp++;
        if (grant_dout !== 4'b0100) begin n_bad++; $display("FAIL single_grant got=%b want=0100", grant_dout); end
        n_cmp++;
        if (channel_dout !== 48'h02a987654321) begin n_bad++; $display("FAIL single_ch got=%h want=02a987654321", channel_dout); end
        n_cmp++;
        if (diff_pair_dout !== 2'b01) begin n_bad++; $display("FAIL single_dp got=%b want=01", diff_pair_dout); end
        n_cmp++;
        if (credit_count_dout !== 4'd3) begin n_bad++; $display("FAIL single_credit got=%0d want=3", credit_count_dout); end
        request_din = '0;
        tick();
        n_cmp++;
        if (grant_dout !== 4'b0000) begin n_bad++; $display("FAIL single_grant_drop got=%b want=0000", grant_dout); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] want_g;
        logic [1:0]    want_dp;
        do_reset();
        randomize_channels();
        request_din = 4'b1111;
        credit_din  = 1'b1;
        for (int n = 0; n < 5; n++) begin
            want_g  = 4'b0001 << (n % NR);
            want_dp = (n % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            n_cmp++;
            if (grant_dout !== want_g || diff_pair_dout !== want_dp || channel_dout !== m_ch
                || credit_count_dout !== 4'd4) begin
                n_bad++;
                $display("FAIL rr_launch%0d got g=%b dp=%b ch=%h cr=%0d want g=%b dp=%b ch=%h cr=4",
                         n, grant_dout, diff_pair_dout, channel_dout, credit_count_dout, want_g, want_dp, m_ch);
            end
            tick();
            n_cmp++;
            if (grant_dout !== 4'b0000 || diff_pair_dout !== want_dp) begin
                n_bad++;
                $display("FAIL rr_gap%0d got g=%b dp=%b want g=0000 dp=%b", n, grant_dout, diff_pair_dout, want_dp);
            end
        end
        credit_din  = 1'b0;
        request_din = '0;
    endtask

    task automatic test_credit_exhaustion();
        int grants;
        do_reset();
        randomize_channels();
        request_din = 4'b0001;
        grants = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (grant_dout != '0) grants++;
            n_cmp++;
            if ({grant_dout, diff_pair_dout, credit_count_dout} !== {m_gnt, m_dp, m_credit}) begin
                n_bad++;
                $display("FAIL exhaust_cycle%0d got g=%b dp=%b cr=%0d want g=%b dp=%b cr=%0d",
                         n, grant_dout, diff_pair_dout, credit_count_dout, m_gnt, m_dp, m_credit);
            end
        end
        n_cmp++;
        if (grants != 4 || credit_count_dout !== 4'd0 || diff_pair_dout !== 2'b10) begin
            n_bad++;
            $display("FAIL exhaust_total got grants=%0d cr=%0d dp=%b want grants=4 cr=0 dp=10",
                     grants, credit_count_dout, diff_pair_dout);
        end
        credit_din = 1'b1;
        tick();
        credit_din = 1'b0;
        grants = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (grant_dout != '0) grants++;
        end
        n_cmp++;
        if (grants != 1 || credit_count_dout !== 4'd0 || diff_pair_dout !== 2'b01) begin
            n_bad++;
            $display("FAIL exhaust_refill got grants=%0d cr=%0d dp=%b want grants=1 cr=0 dp=01",
                     grants, credit_count_dout, diff_pair_dout);
        end
        request_din = '0;
    endtask

    task automatic test_simultaneous_credit();
        do_reset();
        randomize_channels();
        request_din = 4'b0001;
        credit_din  = 1'b1;
        tick();
        n_cmp++;
        if (grant_dout !== 4'b0001 || credit_count_dout !== 4'd4) begin
            n_bad++;
            $display("FAIL simul_credit got g=%b cr=%0d want g=0001 cr=4", grant_dout, credit_count_dout);
        end
        request_din = '0;
        credit_din  = 1'b0;
        tick();
        credit_din = 1'b1;
        repeat (10) tick();
        credit_din = 1'b0;
        n_cmp++;
        if (credit_count_dout !== 4'd4) begin
            n_bad++;
            $display("FAIL surplus_credit got=%0d want=4", credit_count_dout);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            request_din = 4'($urandom_range(0, 15));
            credit_din  = ($urandom_range(0, 2) == 0);
            randomize_channels();
            tick();
            n_cmp++;
            if ({grant_dout, diff_pair_dout, channel_dout, credit_count_dout} !== {m_gnt, m_dp, m_ch, m_credit}) begin
                n_bad++;
                $display("FAIL random_cycle%0d got g=%b dp=%b ch=%h cr=%0d want g=%b dp=%b ch=%h cr=%0d",
                         n, grant_dout, diff_pair_dout, channel_dout, credit_count_dout,
                         m_gnt, m_dp, m_ch, m_credit);
            end
`ifdef OUTPORT_FLIT_COUNT_EN
            n_cmp++;
            if (flit_count_dout !== m_flits) begin
                n_bad++;
                $display("FAIL random_flits%0d got=%0d want=%0d", n, flit_count_dout, m_flits);
            end
`endif
        end
        request_din = '0;
        credit_din  = 1'b0;
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        randomize_channels();
        request_din = 4'b0010;
        tick();
        n_cmp++;
        if (grant_dout !== 4'b0010) begin n_bad++; $display("FAIL midreset_pre got g=%b want 0010", grant_dout); end
        #2;
        rsta_n = 1'b0;
        #1;
        n_cmp++;
        if ({grant_dout, diff_pair_dout, channel_dout, credit_count_dout} !== {4'b0000, 2'b10, 48'h0, 4'd4}) begin
            n_bad++;
            $display("FAIL midreset got g=%b dp=%b ch=%h cr=%0d want g=0000 dp=10 ch=0 cr=4",
                     grant_dout, diff_pair_dout, channel_dout, credit_count_dout);
        end
`ifdef OUTPORT_FLIT_COUNT_EN
        n_cmp++;
        if (flit_count_dout !== 16'd0) begin n_bad++; $display("FAIL midreset_flits got=%0d want=0", flit_count_dout); end
`endif
        request_din = '0;
        @(posedge clka);
        #1;
        rsta_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_flit();
        test_round_robin();
        test_credit_exhaustion();
        test_simultaneous_credit();
        test_random();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
